// File: rtl/rr_arbiter_generic_pkg.sv
// Shared types for the round-robin arbiter slice.
package rr_arbiter_generic_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/priority_encoder_generic.sv
// Generic priority encoder: y is the index of the highest set bit of x, z flags any bit set.
module priority_encoder_generic #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  x,
    output logic [IW-1:0] y,
    output logic          z
);

    // Later (higher) indices overwrite earlier ones, so the top set bit wins.
    always_comb begin
        y = '0;
        z = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                y = IW'(i);
                z = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_generic.sv
// Round-robin arbiter: rotating-priority search, registered one-hot grant,
// held until release, owner withdrawal or MAX_HOLD expiry.
module rr_arbiter_generic
    import rr_arbiter_generic_pkg::*;
#(
    parameter int N        = 6,
    parameter int MAX_HOLD = 8,
    localparam int IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          rel,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid,
    output logic          timeout
);

    localparam int HW = (MAX_HOLD > 0) ? (($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1) : 1;

    arb_state_t    state, state_d;
    logic [IW-1:0] ptr, ptr_d;
    logic [HW-1:0] hold_cnt, hold_cnt_d;
    logic [N-1:0]  gnt_d;
    logic [IW-1:0] gnt_idx_d;
    logic          gnt_valid_d;
    logic          timeout_d;

    logic [N-1:0]  rev_masked;
    logic [N-1:0]  rev_req;
    logic [IW-1:0] y_masked, y_unmasked;
    logic          z_masked, z_unmasked;
    logic [IW-1:0] winner;

    // The encoders favour the highest index, so feed them bit-reversed vectors
    // and map back with N-1-y to make the lowest index at or above ptr win.
    always_comb begin
        rev_masked = '0;
        rev_req    = '0;
        for (int k = 0; k < N; k++) begin
            rev_req[k]    = req[N-1-k];
            rev_masked[k] = req[N-1-k] & (IW'(N-1-k) >= ptr);
        end
    end

    priority_encoder_generic #(.N(N), .IW(IW)) u_enc_masked (
        .x (rev_masked),
        .y (y_masked),
        .z (z_masked)
    );

    priority_encoder_generic #(.N(N), .IW(IW)) u_enc_unmasked (
        .x (rev_req),
        .y (y_unmasked),
        .z (z_unmasked)
    );

    assign winner = z_masked ? (IW'(N-1) - y_masked) : (IW'(N-1) - y_unmasked);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            hold_cnt  <= hold_cnt_d;
            gnt       <= gnt_d;
            gnt_idx   <= gnt_idx_d;
            gnt_valid <= gnt_valid_d;
            timeout   <= timeout_d;
        end
    end

    // Release (rel or withdrawal) outranks expiry, so timeout only fires on a pure expiry.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        hold_cnt_d  = hold_cnt;
        gnt_d       = gnt;
        gnt_idx_d   = gnt_idx;
        gnt_valid_d = gnt_valid;
        timeout_d   = 1'b0;

        unique case (state)
            IDLE: begin
                if (z_unmasked) begin
                    gnt_d       = N'(1) << winner;
                    gnt_idx_d   = winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (rel || !req[gnt_idx] ||
                    ((MAX_HOLD > 0) && (hold_cnt == HW'(MAX_HOLD - 1)))) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    state_d     = IDLE;
                    ptr_d       = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
                    timeout_d   = !(rel || !req[gnt_idx]);
                end else if (hold_cnt != '1) begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter_generic.sv
// Self-checking bench for rr_arbiter_generic against a queue-free behavioural round-robin model.
module tb_rr_arbiter_generic;

    localparam int N        = 6;
    localparam int MAX_HOLD = 8;
    localparam int IW       = $clog2(N);

    logic          clk;
    logic          reset_n;
    logic [N-1:0]  req;
    logic          rel;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          timeout;

    int total;
    int bad;

    // Reference model: who owns the resource, for how many cycles, and where the next search starts.
    bit m_busy;
    int m_owner;
    int m_tenure;
    int m_ptr;
    int m_last_idx;
    bit m_timeout;

    rr_arbiter_generic #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        m_busy     = 1'b0;
        m_owner    = 0;
        m_tenure   = 0;
        m_ptr      = 0;
        m_last_idx = 0;
        m_timeout  = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic modelStep(input logic [N-1:0] r, input logic rl);
        int cand;
        m_timeout = 1'b0;
        if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
                cand = (m_ptr + i) % N;
                if (r[cand]) begin
                    m_busy     = 1'b1;
                    m_owner    = cand;
                    m_last_idx = cand;
                    m_tenure   = 1;
                    break;
                end
            end
        end else if (rl || !r[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
        end else if (MAX_HOLD > 0 && m_tenure == MAX_HOLD) begin
            m_busy    = 1'b0;
            m_ptr     = (m_owner + 1) % N;
            m_timeout = 1'b1;
        end else begin
            m_tenure++;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [N-1:0]  exp_gnt;
        logic [IW-1:0] exp_idx;
        exp_gnt = m_busy ? (N'(1) << m_owner) : '0;
        exp_idx = IW'(m_last_idx);
        total += 4;
        assert (gnt === exp_gnt) else begin
            bad++;
            $error("[TB] FAIL %s gnt: got %b, want %b", tag, gnt, exp_gnt);
        end
        assert (gnt_valid === m_busy) else begin
            bad++;
            $error("[TB] FAIL %s gnt_valid: got %b, want %b", tag, gnt_valid, m_busy);
        end
        assert (gnt_idx === exp_idx) else begin
            bad++;
            $error("[TB] FAIL %s gnt_idx: got %0d, want %0d", tag, gnt_idx, exp_idx);
        end
        assert (timeout === m_timeout) else begin
            bad++;
            $error("[TB] FAIL %s timeout: got %b, want %b", tag, timeout, m_timeout);
        end
    endtask

    // Called at a negedge: drive inputs, step model, check #1 after the rising edge, return at next negedge.
    task automatic applyStimulus(input logic [N-1:0] r, input logic rl, input string tag);
        req = r;
        rel = rl;
        modelStep(r, rl);
        @(posedge clk);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] r_req;
        total   = 0;
        bad     = 0;
        req     = '1;
        rel     = 1'b0;
        reset_n = 1'b1;
        modelReset();

        // Reset asserted asynchronously, outputs cleared before any clock edge.
        #1 reset_n = 1'b0;
        #1 checkOutput("reset_async");
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(6'b111111, 1'b0, "first_grant");

        // Full rotation 0..5 then back to 0, each grant released by rel.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(6'b111111, 1'b1, "rot_release");
            applyStimulus(6'b111111, 1'b0, "rot_grant");
        end
        applyStimulus(6'b111111, 1'b1, "rot_release_last");

        // Skip and wrap.
        applyStimulus(6'b000100, 1'b0, "skip_grant2");
        applyStimulus(6'b000100, 1'b1, "skip_rel2");
        applyStimulus(6'b100100, 1'b0, "skip_grant5");
        applyStimulus(6'b100100, 1'b1, "skip_rel5");
        applyStimulus(6'b100100, 1'b0, "wrap_grant2");
        applyStimulus(6'b100100, 1'b1, "wrap_rel2");

        // Timeout: eight grant cycles, then a one-cycle timeout pulse.
        for (int i = 0; i < 9; i++) applyStimulus(6'b010000, 1'b0, "hold_timeout");
        applyStimulus(6'b000000, 1'b0, "timeout_clear");
        applyStimulus(6'b111111, 1'b0, "after_timeout_grant5");
        applyStimulus(6'b111111, 1'b1, "after_timeout_rel");

        // rel on the final permitted cycle takes precedence over expiry.
        for (int i = 0; i < 8; i++) applyStimulus(6'b010000, 1'b0, "hold_to_limit");
        applyStimulus(6'b010000, 1'b1, "rel_at_limit");
        applyStimulus(6'b000000, 1'b0, "rel_at_limit_idle");

        // Withdrawal after three grant cycles.
        for (int i = 0; i < 3; i++) applyStimulus(6'b000010, 1'b0, "withdraw_hold");
        applyStimulus(6'b000000, 1'b0, "withdraw_drop");
        applyStimulus(6'b111111, 1'b0, "withdraw_next_grant2");

        // Reset mid-operation while requester 3 owns the resource.
        applyStimulus(6'b111111, 1'b1, "pre_reset_rel");
        applyStimulus(6'b111111, 1'b0, "pre_reset_grant3");
        #3 reset_n = 1'b0;
        modelReset();
        #1 checkOutput("reset_midop");
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(6'b111111, 1'b0, "post_reset_grant0");
        applyStimulus(6'b111111, 1'b1, "post_reset_rel");

        // Randomised traffic; req is kept stable for stretches so expiries occur.
        r_req = N'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) r_req = N'($urandom);
            applyStimulus(r_req, ($urandom_range(0, 9) == 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
